// File: rtl/lcd_reader_if.sv
// Host-side request/response and LCD pin bundle for lcd_reader.
// slave = the reader engine, master = the requester / pin mux side.
interface lcd_reader_if;
   logic       do_read;
   logic       read_rs;
   logic       poll_busy;
   logic [3:0] lcddat_in;
   logic       lcde;
   logic       lcdrs;
   logic       lcdrw;
   logic       lcd_bus_req;
   logic       read_busy;
   logic       read_done;
   logic [7:0] read_data;
   logic       poll_timeout;

   modport slave (
      input  do_read, read_rs, poll_busy, lcddat_in,
      output lcde, lcdrs, lcdrw, lcd_bus_req, read_busy, read_done, read_data, poll_timeout
   );

   modport master (
      output do_read, read_rs, poll_busy, lcddat_in,
      input  lcde, lcdrs, lcdrw, lcd_bus_req, read_busy, read_done, read_data, poll_timeout
   );
endinterface

// File: rtl/lcd_reader.sv
// 4-bit HD44780 read engine: two-nibble read of busy flag/address or data byte.
// Optional busy-poll loop enabled with macro LCD_READER_BUSY_POLL_EN.
module lcd_reader #(
   parameter int SETUP_CYC  = 2,
   parameter int E_HIGH_CYC = 12,
   parameter int HOLD_CYC   = 1,
   parameter int GAP_CYC    = 50,
   parameter int POLL_MAX   = 255
) (
   input  logic        clk,
   input  logic        reset,
   lcd_reader_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_EHIGH, S_HOLD, S_GAP, S_DONE
   } state_t;

   localparam logic [15:0] C_SETUP = 16'(SETUP_CYC);
   localparam logic [15:0] C_EHIGH = 16'(E_HIGH_CYC);
   localparam logic [15:0] C_HOLD  = 16'(HOLD_CYC);
   localparam logic [15:0] C_GAP   = 16'(GAP_CYC);

   state_t      r_state, w_state_next;
   logic [15:0] r_cnt, w_cnt_next;
   logic        r_nib, w_nib_next;
   logic        r_rs, w_rs_next;
   logic [7:0]  r_data, w_data_next;
   logic        w_last;
   logic        w_restart;
   logic        w_timeout_hit;

   logic r_lcde, r_lcdrs, r_lcdrw, r_bus_req, r_busy, r_done, r_timeout;
   logic w_lcde_o, w_lcdrs_o, w_lcdrw_o, w_bus_req_o, w_busy_o, w_done_o, w_timeout_o;

   assign w_last = (r_cnt == 16'd1);

`ifdef LCD_READER_BUSY_POLL_EN
   logic        r_poll;
   logic [15:0] r_reads;

   // Poll mode only applies to status reads; r_reads counts completed byte reads.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_poll  <= 1'b0;
         r_reads <= 16'd0;
      end else if (r_state == S_IDLE && bus.do_read) begin
         r_poll  <= bus.poll_busy & ~bus.read_rs;
         r_reads <= 16'd0;
      end else if (r_state == S_HOLD && w_last && r_nib) begin
         r_reads <= r_reads + 16'd1;
      end
   end

   assign w_restart     = r_poll && r_data[7] && ((r_reads + 16'd1) < 16'(POLL_MAX));
   assign w_timeout_hit = r_poll && r_data[7];
`else
   assign w_restart     = 1'b0;
   assign w_timeout_hit = 1'b0;
`endif

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = (r_cnt > 16'd1) ? r_cnt - 16'd1 : r_cnt;
      w_nib_next   = r_nib;
      w_rs_next    = r_rs;
      w_data_next  = r_data;

      case (r_state)
         S_IDLE: begin
            if (bus.do_read) begin
               w_rs_next    = bus.read_rs;
               w_nib_next   = 1'b0;
               w_state_next = S_SETUP;
               w_cnt_next   = C_SETUP;
            end
         end
         S_SETUP: begin
            if (w_last) begin
               w_state_next = S_EHIGH;
               w_cnt_next   = C_EHIGH;
            end
         end
         S_EHIGH: begin
            if (w_last) begin
               if (r_nib) w_data_next[3:0] = bus.lcddat_in;
               else       w_data_next[7:4] = bus.lcddat_in;
               w_state_next = S_HOLD;
               w_cnt_next   = C_HOLD;
            end
         end
         S_HOLD: begin
            if (w_last) begin
               if (!r_nib || w_restart) begin
                  w_state_next = S_GAP;
                  w_cnt_next   = C_GAP;
               end else begin
                  w_state_next = S_DONE;
                  w_cnt_next   = 16'd1;
               end
            end
         end
         S_GAP: begin
            // Toggling covers both high->low nibble and a poll restart back to high.
            if (w_last) begin
               w_nib_next   = ~r_nib;
               w_state_next = S_SETUP;
               w_cnt_next   = C_SETUP;
            end
         end
         S_DONE: begin
            w_state_next = S_IDLE;
            w_cnt_next   = 16'd0;
         end
         default: begin
            w_state_next = S_IDLE;
            w_cnt_next   = 16'd0;
         end
      endcase

      w_busy_o    = (r_state != S_IDLE);
      w_bus_req_o = w_busy_o;
      w_lcdrw_o   = w_busy_o;
      w_lcdrs_o   = w_busy_o & r_rs;
      w_lcde_o    = (r_state == S_EHIGH);
      w_done_o    = (r_state == S_DONE);
      w_timeout_o = (r_state == S_DONE) & w_timeout_hit;
   end

   // Pin/status outputs trail the state by one cycle so E is a clean flop output.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= 16'd0;
         r_nib     <= 1'b0;
         r_rs      <= 1'b0;
         r_data    <= 8'h00;
         r_lcde    <= 1'b0;
         r_lcdrs   <= 1'b0;
         r_lcdrw   <= 1'b0;
         r_bus_req <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_nib     <= w_nib_next;
         r_rs      <= w_rs_next;
         r_data    <= w_data_next;
         r_lcde    <= w_lcde_o;
         r_lcdrs   <= w_lcdrs_o;
         r_lcdrw   <= w_lcdrw_o;
         r_bus_req <= w_bus_req_o;
         r_busy    <= w_busy_o;
         r_done    <= w_done_o;
         r_timeout <= w_timeout_o;
      end
   end

   assign bus.lcde         = r_lcde;
   assign bus.lcdrs        = r_lcdrs;
   assign bus.lcdrw        = r_lcdrw;
   assign bus.lcd_bus_req  = r_bus_req;
   assign bus.read_busy    = r_busy;
   assign bus.read_done    = r_done;
   assign bus.read_data    = r_data;
   assign bus.poll_timeout = r_timeout;

endmodule
